core_exu_pipe: RTL and testbench

Parametrised execute stage that replaces the single-entry, 32-bit execute stage. It sits between the decode stage and the writeback stage, using valid/ready on both sides, and resolves ALU, branch and jump operations in one cycle. It adds an iterative multiplier (MUL/MULH/MULHSU/MULHU), a configurable-depth output queue so writeback back-pressure does not immediately stall decode, and a synchronous pipeline flush for branch redirects.

---
 rtl/core_exu_pkg.sv | 62 ++++++
 rtl/core_exu_mul_iter.sv | 94 +++++++++
 rtl/core_exu_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_core_exu_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_exu_pkg.sv
// Shared definitions for the execute stage: op encodings, multiplier modes,
// decode predicates and the output-queue entry layout.
package core_exu_pkg;

  localparam int unsigned OP_W     = 5;
  localparam int unsigned RD_IDX_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLT    = 5'd5,
    OP_SLTU   = 5'd6,
    OP_SLL    = 5'd7,
    OP_SRL    = 5'd8,
    OP_SRA    = 5'd9,
    OP_BEQ    = 5'd10,
    OP_BNE    = 5'd11,
    OP_BLT    = 5'd12,
    OP_BGE    = 5'd13,
    OP_BLTU   = 5'd14,
    OP_BGEU   = 5'd15,
    OP_JAL    = 5'd16,
    OP_JALR   = 5'd17,
    OP_MUL    = 5'd18,
    OP_MULH   = 5'd19,
    OP_MULHSU = 5'd20,
    OP_MULHU  = 5'd21
  } exu_op_e;

  typedef enum logic [1:0] {
    MUL_LO  = 2'd0,
    MUL_HH  = 2'd1,
    MUL_HSU = 2'd2,
    MUL_HU  = 2'd3
  } mul_mode_e;

  // Queue entry field order, MSB first: {res, rd_idx, pc, bc_done, bc_en, bc_pc}.
  function automatic int unsigned q_entry_w(input int unsigned xlen);
    return 3 * xlen + RD_IDX_W + 2;
  endfunction

  function automatic logic op_is_mul(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic op_is_bc(input logic [OP_W-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_JALR);
  endfunction

  function automatic mul_mode_e mul_mode_of(input logic [OP_W-1:0] op);
    case (op)
      OP_MULH:   return MUL_HH;
      OP_MULHSU: return MUL_HSU;
      OP_MULHU:  return MUL_HU;
      default:   return MUL_LO;
    endcase
  endfunction

endpackage

// File: rtl/core_exu_mul_iter.sv
// Iterative shift-add multiplier on operand magnitudes. done/res are valid
// combinationally during the final iteration so the caller can enqueue at that edge.
module core_exu_mul_iter
  import core_exu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            start,
  input  mul_mode_e       mode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int unsigned ITERS  = XLEN / MUL_STEP;
  localparam int unsigned CNT_W  = $clog2(ITERS + 1);
  localparam int unsigned SUM_W  = XLEN + MUL_STEP;
  localparam int unsigned PROD_W = 2 * XLEN;

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [SUM_W-1:0]  sum;
  logic [PROD_W-1:0] prod_step, prod_sgn;

  // Upper half accumulates mcand * low multiplier bits, then the whole product shifts right.
  always_comb begin
    a_neg     = ((mode == MUL_HH) || (mode == MUL_HSU)) & a[XLEN-1];
    b_neg     = (mode == MUL_HH) & b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    sum       = SUM_W'(prod_q[PROD_W-1:XLEN]) + SUM_W'(mcand_q) * SUM_W'(prod_q[MUL_STEP-1:0]);
    prod_step = PROD_W'({sum, prod_q[XLEN-1:0]} >> MUL_STEP);
    prod_sgn  = neg_q ? -prod_step : prod_step;
    res       = hi_q ? prod_sgn[PROD_W-1:XLEN] : prod_sgn[XLEN-1:0];
    done      = busy_q & (cnt_q == CNT_W'(1));
    busy      = busy_q;
  end

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    if (kill) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_W'(ITERS);
      prod_d  = {XLEN'(0), b_mag};
      mcand_d = a_mag;
      neg_d   = a_neg ^ b_neg;
      hi_d    = (mode != MUL_LO);
    end else if (busy_q) begin
      prod_d = prod_step;
      cnt_d  = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/core_exu_pipe.sv
// Execute stage: single-cycle ALU/branch resolution, iterative multiplier and an
// OUT_DEPTH-entry result queue toward writeback, with synchronous flush.
module core_exu_pipe
  import core_exu_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned MUL_STEP  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                exu_rx_valid,
  output logic                exu_rx_ready,
  input  logic [OP_W-1:0]     exu_rx_op,
  input  logic [XLEN-1:0]     exu_rx_rs1,
  input  logic [XLEN-1:0]     exu_rx_rs2,
  input  logic [XLEN-1:0]     exu_rx_imme,
  input  logic [XLEN-1:0]     exu_rx_pc,
  input  logic [RD_IDX_W-1:0] exu_rx_rd_idx,
  output logic                exu_tx_valid,
  input  logic                exu_tx_ready,
  output logic [XLEN-1:0]     exu_tx_res,
  output logic [RD_IDX_W-1:0] exu_tx_rd_idx,
  output logic [XLEN-1:0]     exu_tx_pc,
  output logic                exu_tx_bc_done,
  output logic                exu_tx_bc_en,
  output logic [XLEN-1:0]     exu_tx_bc_pc
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0]     res;
    logic [RD_IDX_W-1:0] rd_idx;
    logic [XLEN-1:0]     pc;
    logic                bc_done;
    logic                bc_en;
    logic [XLEN-1:0]     bc_pc;
  } q_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_e;

  state_e         state_q, state_d;
  q_entry_t       q_mem_q [OUT_DEPTH];
  q_entry_t       q_mem_d [OUT_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  q_entry_t       mul_ent_q, mul_ent_d;

  q_entry_t        alu_ent, enq_ent, head;
  logic            enq, tx_valid, tx_fire, rx_fire, space, rx_ready;
  logic            mul_start, mul_busy, mul_done;
  logic [XLEN-1:0] mul_res, br_tgt, link;
  logic [SHW-1:0]  shamt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Single-cycle result for every non-multiply op.
  always_comb begin
    alu_ent         = '0;
    alu_ent.rd_idx  = exu_rx_rd_idx;
    alu_ent.pc      = exu_rx_pc;
    alu_ent.bc_done = op_is_bc(exu_rx_op);
    br_tgt          = exu_rx_pc + exu_rx_imme;
    link            = exu_rx_pc + XLEN'(4);
    shamt           = exu_rx_rs2[SHW-1:0];
    case (exu_rx_op)
      OP_ADD:  alu_ent.res = exu_rx_rs1 + exu_rx_rs2;
      OP_SUB:  alu_ent.res = exu_rx_rs1 - exu_rx_rs2;
      OP_AND:  alu_ent.res = exu_rx_rs1 & exu_rx_rs2;
      OP_OR:   alu_ent.res = exu_rx_rs1 | exu_rx_rs2;
      OP_XOR:  alu_ent.res = exu_rx_rs1 ^ exu_rx_rs2;
      OP_SLT:  alu_ent.res = XLEN'($signed(exu_rx_rs1) < $signed(exu_rx_rs2));
      OP_SLTU: alu_ent.res = XLEN'(exu_rx_rs1 < exu_rx_rs2);
      OP_SLL:  alu_ent.res = exu_rx_rs1 << shamt;
      OP_SRL:  alu_ent.res = exu_rx_rs1 >> shamt;
      OP_SRA:  alu_ent.res = XLEN'($signed(exu_rx_rs1) >>> shamt);
      OP_BEQ:  begin alu_ent.bc_en = (exu_rx_rs1 == exu_rx_rs2); alu_ent.bc_pc = br_tgt; end
      OP_BNE:  begin alu_ent.bc_en = (exu_rx_rs1 != exu_rx_rs2); alu_ent.bc_pc = br_tgt; end
      OP_BLT:  begin alu_ent.bc_en = ($signed(exu_rx_rs1) < $signed(exu_rx_rs2)); alu_ent.bc_pc = br_tgt; end
      OP_BGE:  begin alu_ent.bc_en = ($signed(exu_rx_rs1) >= $signed(exu_rx_rs2)); alu_ent.bc_pc = br_tgt; end
      OP_BLTU: begin alu_ent.bc_en = (exu_rx_rs1 < exu_rx_rs2); alu_ent.bc_pc = br_tgt; end
      OP_BGEU: begin alu_ent.bc_en = (exu_rx_rs1 >= exu_rx_rs2); alu_ent.bc_pc = br_tgt; end
      OP_JAL:  begin alu_ent.bc_en = 1'b1; alu_ent.bc_pc = br_tgt; alu_ent.res = link; end
      OP_JALR: begin
        alu_ent.bc_en = 1'b1;
        alu_ent.bc_pc = (exu_rx_rs1 + exu_rx_imme) & ~XLEN'(1);
        alu_ent.res   = link;
      end
      default: ;
    endcase
  end

  // Handshake, FSM next state and queue bookkeeping; flush overrides all of it.
  always_comb begin
    tx_valid  = (cnt_q != '0);
    tx_fire   = tx_valid & exu_tx_ready;
    space     = (cnt_q < CNT_W'(OUT_DEPTH)) | tx_fire;
    rx_ready  = ~rst & ~flush & (state_q == ST_IDLE) & space;
    rx_fire   = exu_rx_valid & rx_ready;

    state_d   = state_q;
    enq       = 1'b0;
    mul_start = 1'b0;
    mul_ent_d = mul_ent_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          if (op_is_mul(exu_rx_op)) begin
            mul_start        = ~mul_busy;
            mul_ent_d        = '0;
            mul_ent_d.rd_idx = exu_rx_rd_idx;
            mul_ent_d.pc     = exu_rx_pc;
            state_d          = ST_MUL;
          end else begin
            enq = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          mul_ent_d.res = mul_res;
          if (space) begin
            enq     = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (space) begin
          enq     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    enq_ent = (state_q == ST_IDLE) ? alu_ent : mul_ent_d;

    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) begin
      q_mem_d[wr_ptr_q] = enq_ent;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (tx_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(tx_fire);

    if (flush) begin
      state_d   = ST_IDLE;
      mul_start = 1'b0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
    end
  end

  core_exu_mul_iter #(
    .XLEN     (XLEN),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .kill  (flush),
    .start (mul_start),
    .mode  (mul_mode_of(exu_rx_op)),
    .a     (exu_rx_rs1),
    .b     (exu_rx_rs2),
    .busy  (mul_busy),
    .done  (mul_done),
    .res   (mul_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      mul_ent_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      mul_ent_q <= mul_ent_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    q_mem_q <= q_mem_d;
  end

  always_comb begin
    head           = tx_valid ? q_mem_q[rd_ptr_q] : '0;
    exu_rx_ready   = rx_ready;
    exu_tx_valid   = tx_valid;
    exu_tx_res     = head.res;
    exu_tx_rd_idx  = head.rd_idx;
    exu_tx_pc      = head.pc;
    exu_tx_bc_done = head.bc_done;
    exu_tx_bc_en   = head.bc_en;
    exu_tx_bc_pc   = head.bc_pc;
  end

endmodule

// File: tb/tb_core_exu_pipe.sv
// Directed bench for core_exu_pipe (XLEN=32, OUT_DEPTH=2, MUL_STEP=1).
module tb_core_exu_pipe;
  import core_exu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        exu_rx_valid, exu_rx_ready;
  logic [4:0]  exu_rx_op;
  logic [31:0] exu_rx_rs1, exu_rx_rs2, exu_rx_imme, exu_rx_pc;
  logic [4:0]  exu_rx_rd_idx;
  logic        exu_tx_valid, exu_tx_ready;
  logic [31:0] exu_tx_res, exu_tx_pc, exu_tx_bc_pc;
  logic [4:0]  exu_tx_rd_idx;
  logic        exu_tx_bc_done, exu_tx_bc_en;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  core_exu_pipe #(.XLEN(32), .OUT_DEPTH(2), .MUL_STEP(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .exu_rx_valid(exu_rx_valid), .exu_rx_ready(exu_rx_ready), .exu_rx_op(exu_rx_op),
    .exu_rx_rs1(exu_rx_rs1), .exu_rx_rs2(exu_rx_rs2), .exu_rx_imme(exu_rx_imme),
    .exu_rx_pc(exu_rx_pc), .exu_rx_rd_idx(exu_rx_rd_idx),
    .exu_tx_valid(exu_tx_valid), .exu_tx_ready(exu_tx_ready), .exu_tx_res(exu_tx_res),
    .exu_tx_rd_idx(exu_tx_rd_idx), .exu_tx_pc(exu_tx_pc), .exu_tx_bc_done(exu_tx_bc_done),
    .exu_tx_bc_en(exu_tx_bc_en), .exu_tx_bc_pc(exu_tx_bc_pc)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imme, input logic [31:0] pc, input logic [4:0] rd);
    exu_rx_op = op; exu_rx_rs1 = rs1; exu_rx_rs2 = rs2;
    exu_rx_imme = imme; exu_rx_pc = pc; exu_rx_rd_idx = rd;
    exu_rx_valid = 1'b1;
  endtask

  // Offer an op and wait (bounded) until it is accepted.
  task automatic issue(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd);
    int n;
    drive(op, rs1, rs2, 32'h0, 32'h0, rd);
    #1;
    n = 0;
    while (!exu_rx_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n == 50) check("issue_timeout", 64'd0, 64'd1);
    cyc();
    exu_rx_valid = 1'b0;
  endtask

  task automatic op_test(input string tag, input logic [4:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imme, input logic [31:0] pc,
                         input logic [31:0] e_res, input logic e_done, input logic e_en,
                         input logic [31:0] e_bcpc);
    exu_tx_ready = 1'b1;
    drive(op, rs1, rs2, imme, pc, 5'd9);
    cyc();
    exu_rx_valid = 1'b0;
    check({tag, "_valid"}, 64'(exu_tx_valid), 64'd1);
    check({tag, "_res"}, 64'(exu_tx_res), 64'(e_res));
    check({tag, "_bc_done"}, 64'(exu_tx_bc_done), 64'(e_done));
    check({tag, "_bc_en"}, 64'(exu_tx_bc_en), 64'(e_en));
    check({tag, "_bc_pc"}, 64'(exu_tx_bc_pc), 64'(e_bcpc));
    cyc();
  endtask

  task automatic mul_test(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_res);
    int lat, stall;
    exu_tx_ready = 1'b1;
    drive(op, a, b, 32'h0, 32'h80, 5'd7);
    #1;
    check({tag, "_accept"}, 64'(exu_rx_ready), 64'd1);
    cyc();
    exu_rx_valid = 1'b0;
    lat = 1;
    stall = 0;
    while (!exu_tx_valid && lat < 100) begin
      if (!exu_rx_ready) stall++;
      cyc();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_stall"}, 64'(stall), 64'd32);
    check({tag, "_res"}, 64'(exu_tx_res), 64'(e_res));
    check({tag, "_rd"}, 64'(exu_tx_rd_idx), 64'd7);
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ghost;
    rst = 1'b1; flush = 1'b0; exu_tx_ready = 1'b0;
    exu_rx_valid = 1'b0; exu_rx_op = '0; exu_rx_rs1 = '0; exu_rx_rs2 = '0;
    exu_rx_imme = '0; exu_rx_pc = '0; exu_rx_rd_idx = '0;
    repeat (2) cyc();
    check("rst_rx_ready", 64'(exu_rx_ready), 64'd0);
    check("rst_tx_valid", 64'(exu_tx_valid), 64'd0);
    check("rst_tx_res", 64'(exu_tx_res), 64'd0);
    check("rst_bc_done", 64'(exu_tx_bc_done), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 64'(exu_rx_ready), 64'd1);

    // Single ADD, latency 1.
    exu_tx_ready = 1'b1;
    drive(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h10, 5'd3);
    #1;
    check("add_rx_ready", 64'(exu_rx_ready), 64'd1);
    cyc();
    exu_rx_valid = 1'b0;
    check("add_valid", 64'(exu_tx_valid), 64'd1);
    check("add_res", 64'(exu_tx_res), 64'd12);
    check("add_rd", 64'(exu_tx_rd_idx), 64'd3);
    check("add_pc", 64'(exu_tx_pc), 64'h10);
    cyc();
    check("add_pop", 64'(exu_tx_valid), 64'd0);

    // Ten back-to-back ADDs, one result per cycle.
    for (int i = 0; i < 10; i++) begin
      drive(OP_ADD, 32'(i), 32'd100, 32'd0, 32'd0, 5'(i + 1));
      #1;
      check("b2b_ready", 64'(exu_rx_ready), 64'd1);
      cyc();
      check("b2b_res", 64'(exu_tx_res), 64'(i + 100));
      check("b2b_rd", 64'(exu_tx_rd_idx), 64'(i + 1));
    end
    exu_rx_valid = 1'b0;
    cyc();
    check("b2b_drain", 64'(exu_tx_valid), 64'd0);

    // Queue full, then enqueue and pop in the same cycle.
    exu_tx_ready = 1'b0;
    drive(OP_ADD, 32'd1, 32'd0, 32'd0, 32'd0, 5'd1);
    #1;
    check("full_rdy1", 64'(exu_rx_ready), 64'd1);
    cyc();
    drive(OP_ADD, 32'd2, 32'd0, 32'd0, 32'd0, 5'd2);
    #1;
    check("full_rdy2", 64'(exu_rx_ready), 64'd1);
    cyc();
    drive(OP_ADD, 32'd3, 32'd0, 32'd0, 32'd0, 5'd3);
    #1;
    check("full_stall", 64'(exu_rx_ready), 64'd0);
    cyc();
    check("full_stall_hold", 64'(exu_rx_ready), 64'd0);
    check("full_head", 64'(exu_tx_res), 64'd1);
    exu_tx_ready = 1'b1;
    #1;
    check("full_same_cycle", 64'(exu_rx_ready), 64'd1);
    cyc();
    exu_rx_valid = 1'b0;
    check("full_order2", 64'(exu_tx_res), 64'd2);
    cyc();
    check("full_order3", 64'(exu_tx_res), 64'd3);
    cyc();
    check("full_empty", 64'(exu_tx_valid), 64'd0);

    // Multiplier variants.
    mul_test("mulh_neg", OP_MULH, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    mul_test("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001);
    mul_test("mul_lo", OP_MUL, 32'd6, 32'd7, 32'd42);
    mul_test("mul_lo_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    mul_test("mulh_negneg", OP_MULH, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0);
    mul_test("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
    mul_test("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // ALU, branch and jump vectors.
    op_test("sub",  OP_SUB,  32'd3, 32'd5, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    op_test("and",  OP_AND,  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'hF000, 1'b0, 1'b0, 32'h0);
    op_test("or",   OP_OR,   32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'hFFF0, 1'b0, 1'b0, 32'h0);
    op_test("xor",  OP_XOR,  32'hF0F0, 32'hFF00, 32'h0, 32'h0, 32'h0FF0, 1'b0, 1'b0, 32'h0);
    op_test("slt",  OP_SLT,  32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'd1, 1'b0, 1'b0, 32'h0);
    op_test("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'd0, 1'b0, 1'b0, 32'h0);
    op_test("sll",  OP_SLL,  32'd1, 32'h25, 32'h0, 32'h0, 32'h20, 1'b0, 1'b0, 32'h0);
    op_test("srl",  OP_SRL,  32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0800_0000, 1'b0, 1'b0, 32'h0);
    op_test("sra",  OP_SRA,  32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'hF800_0000, 1'b0, 1'b0, 32'h0);
    op_test("blt",  OP_BLT,  32'hFFFF_FFFD, 32'd1, 32'h20, 32'h100, 32'h0, 1'b1, 1'b1, 32'h120);
    op_test("bge",  OP_BGE,  32'hFFFF_FFFD, 32'd1, 32'h20, 32'h100, 32'h0, 1'b1, 1'b0, 32'h120);
    op_test("bltu", OP_BLTU, 32'hFFFF_FFFD, 32'd1, 32'h20, 32'h100, 32'h0, 1'b1, 1'b0, 32'h120);
    op_test("bgeu", OP_BGEU, 32'hFFFF_FFFD, 32'd1, 32'h20, 32'h100, 32'h0, 1'b1, 1'b1, 32'h120);
    op_test("beq",  OP_BEQ,  32'd5, 32'd5, 32'h8, 32'h200, 32'h0, 1'b1, 1'b1, 32'h208);
    op_test("bne",  OP_BNE,  32'd5, 32'd5, 32'h8, 32'h200, 32'h0, 1'b1, 1'b0, 32'h208);
    op_test("jal",  OP_JAL,  32'd0, 32'd0, 32'hFFFF_FFF8, 32'h40, 32'h44, 1'b1, 1'b1, 32'h38);
    op_test("jalr", OP_JALR, 32'h201, 32'd0, 32'h0, 32'h300, 32'h304, 1'b1, 1'b1, 32'h200);
    op_test("undef", 5'd31,  32'd5, 32'd6, 32'h4, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0);

    // Flush with one queued entry and the multiplier mid-iteration.
    exu_tx_ready = 1'b0;
    issue(OP_ADD, 32'd9, 32'd0, 5'd9);
    issue(OP_MUL, 32'd3, 32'd4, 5'd10);
    repeat (5) cyc();
    flush = 1'b1;
    #1;
    check("flush_rx_ready", 64'(exu_rx_ready), 64'd0);
    check("flush_pre_valid", 64'(exu_tx_valid), 64'd1);
    cyc();
    flush = 1'b0;
    exu_tx_ready = 1'b1;
    drive(OP_ADD, 32'd20, 32'd22, 32'd0, 32'd0, 5'd4);
    #1;
    check("flush_valid", 64'(exu_tx_valid), 64'd0);
    check("flush_post_ready", 64'(exu_rx_ready), 64'd1);
    cyc();
    exu_rx_valid = 1'b0;
    check("flush_add_res", 64'(exu_tx_res), 64'd42);
    cyc();
    ghost = 0;
    for (int i = 0; i < 40; i++) begin
      if (exu_tx_valid) ghost++;
      cyc();
    end
    check("flush_no_ghost", 64'(ghost), 64'd0);

    // Reset mid-multiply with a non-empty queue.
    exu_tx_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd1, 5'd2);
    issue(OP_MUL, 32'd5, 32'd5, 5'd3);
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    check("rst2_valid", 64'(exu_tx_valid), 64'd0);
    check("rst2_res", 64'(exu_tx_res), 64'd0);
    check("rst2_rd", 64'(exu_tx_rd_idx), 64'd0);
    check("rst2_pc", 64'(exu_tx_pc), 64'd0);
    check("rst2_bc", 64'({exu_tx_bc_done, exu_tx_bc_en, exu_tx_bc_pc}), 64'd0);
    check("rst2_rx_ready", 64'(exu_rx_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst2_release_ready", 64'(exu_rx_ready), 64'd1);
    ghost = 0;
    for (int i = 0; i < 40; i++) begin
      if (exu_tx_valid) ghost++;
      cyc();
    end
    check("rst2_no_ghost", 64'(ghost), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
